aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Iterative, sequential AES-128 key schedule controller for the encryption datapath.
- On a start pulse it latches a 128-bit cipher key and computes one round key per clock into an internal 11-entry round-key buffer.
- It flags completion and serves round keys to the round logic through a registered read port, indexed by round number.
- Replaces the fully combinational 1408-bit expansion; area is 4 S-boxes plus the buffer.

Parameters:
- NR, 10, number of AES rounds; the buffer holds NR+1 round keys. Only 10 (AES-128) is supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to expand key_in; sampled on clk rising edge
- key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0]
- clr  input  1  synchronous zeroize of the buffer and state
- rd_idx  input  4  round-key index to read, 0..10
- rd_data  output  128  round key rd_idx, registered
- busy  output  1  expansion in progress
- key_ready  output  1  buffer holds a complete, valid schedule
- done  output  1  one-cycle pulse when the schedule completes

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; rnd = 0.
  - All 11 buffer entries = 0.
  - rd_data = 0, busy = 0, key_ready = 0, done = 0.
- States: IDLE, EXPAND, READY.
- IDLE, start = 1 at edge E0:
  - rk[0] <= key_in; rnd <= 1; state <= EXPAND.
  - busy = 1 and key_ready = 0 after E0.
- EXPAND, at each edge:
  - Write rk[rnd] = f(rk[rnd-1], rcon[rnd]); rnd increments.
  - At the edge that writes rk[10]: state <= READY, busy <= 0, key_ready <= 1, done <= 1 for exactly one cycle.
  - rk[10] is written at edge E0+10; done is high during the cycle following E0+10.
- Round function, with p = previous round key split into words p0..p3 (MSB first):
  - t = SubWord(RotWord(p3)) XOR {rcon, 24'h0}.
  - RotWord = {p3[23:0], p3[31:24]}.
  - Outputs: n0 = p0^t, n1 = p1^n0, n2 = p2^n1, n3 = p3^n2.
  - rk = {n0, n1, n2, n3}.
- rcon for rnd 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Held as a table or an xtime register; 8-bit wraparound reduction uses 0x1b.
- S-box: 4 instances of the standard FIPS-197 S-box, combinational, inside this block.
- READY:
  - key_ready stays 1 until a new start or clr.
  - A new start behaves as in IDLE: key_ready drops after the start edge.
- start while busy: ignored; the expansion continues with the original key.
- clr:
  - Has priority over start in any state.
  - Next edge: buffer zeroed, state IDLE, busy/key_ready/done = 0, rd_data = 0.
  - A clr mid-expansion aborts with no done pulse.
- Read port:
  - rd_data <= rk[rd_idx] on every edge, giving a 1-cycle latency.
  - rd_idx > 10 gives rd_data = 0.
  - Reads are allowed in any state. During EXPAND, entries not yet written return their prior contents. Consumers must wait for key_ready.
  - Reading the index written on the same edge returns the old value; no bypass.
- Reset mid-expansion: asynchronous return to the reset values above.

Test Plan:
- Reset, then start with key_in = 2b7e151628aed2a6abf7158809cf4f3c:
  - busy is high for 10 cycles, done pulses once, key_ready = 1.
  - rd_idx = 1 gives a0fafe1788542cb123a339392a6c7605.
  - rd_idx = 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- Start with key_in = 0:
  - rd_idx = 0 gives 0.
  - rd_idx = 1 gives 62636363626363636263636362636363.
  - rd_idx = 10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- Start pulse at cycle 3 of an expansion with a different key_in:
  - Ignored; results match the first key.
  - done is asserted exactly once, 10 cycles after the original start.
- From READY:
  - clr gives key_ready = 0, and rd_data = 0 for all idx 0..10.
  - clr issued mid-expansion gives no done pulse and the state is IDLE.
- Read-port checks:
  - rd_idx = 11..15 gives rd_data = 0.
  - Changing rd_idx shows the new data exactly one cycle later.
- rst_n asserted low between clock edges during EXPAND:
  - Outputs clear immediately, without waiting for an edge.
  - A fresh start after reset produces the correct FIPS-197 schedule.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry buffer,
// served to the round logic through a registered read port indexed by round number.
module aes_key_sched_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         clr,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic         busy,
    output logic         key_ready,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

    // FIPS-197 S-box, byte 0x00 in the most significant position
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTable[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_e       state_q;
    logic [3:0]   rnd_q;
    logic [127:0] rk_q [0:NR];

    logic [3:0]   prev_idx;
    logic [127:0] prev_rk;
    logic [31:0]  p0, p1, p2, p3, t, n0, n1, n2, n3;
    logic [127:0] next_rk;

    // Guard the rnd_q == 0 case so the buffer is never indexed out of range
    assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;

    always_comb begin
        prev_rk = rk_q[prev_idx];
        {p0, p1, p2, p3} = prev_rk;
        t = {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])}
            ^ {rcon(rnd_q), 24'h0};
        n0 = p0 ^ t;
        n1 = p1 ^ n0;
        n2 = p2 ^ n1;
        n3 = p3 ^ n2;
        next_rk = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rnd_q     <= 4'd0;
            rd_data   <= 128'h0;
            busy      <= 1'b0;
            key_ready <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i <= int'(NR); i++) begin
                rk_q[i] <= 128'h0;
            end
        end else begin
            done    <= 1'b0;
            // Reads see the buffer as it was before this edge; no write bypass
            rd_data <= (rd_idx <= 4'(NR)) ? rk_q[rd_idx] : 128'h0;
            if (clr) begin
                state_q   <= StIdle;
                rnd_q     <= 4'd0;
                rd_data   <= 128'h0;
                busy      <= 1'b0;
                key_ready <= 1'b0;
                for (int i = 0; i <= int'(NR); i++) begin
                    rk_q[i] <= 128'h0;
                end
            end else begin
                case (state_q)
                    StIdle, StReady: begin
                        if (start) begin
                            rk_q[0]   <= key_in;
                            rnd_q     <= 4'd1;
                            state_q   <= StExpand;
                            busy      <= 1'b1;
                            key_ready <= 1'b0;
                        end
                    end
                    StExpand: begin
                        rk_q[rnd_q] <= next_rk;
                        rnd_q       <= rnd_q + 4'd1;
                        if (rnd_q == 4'(NR)) begin
                            state_q   <= StReady;
                            busy      <= 1'b0;
                            key_ready <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: FIPS-197 schedules, control corner cases and read port.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic         clr = 1'b0;
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_data;
    logic         busy, key_ready, done;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] exp_q [$];
    string        tag_q [$];
    logic [127:0] fips [0:10];

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .clr       (clr),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .busy      (busy),
        .key_ready (key_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive an index, queue its expected data, and retire it one edge later
    task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        rd_idx = idx;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
    endtask

    task automatic run_expand(input logic [127:0] key, input int inject_at, input int clr_at,
                              output int busy_cnt, output int done_cnt, output int done_at);
        start  = 1'b1;
        key_in = key;
        tick();
        start    = 1'b0;
        key_in   = 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int k = 0; k < 14; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == inject_at) start = 1'b1;
            if (k == clr_at) clr = 1'b1;
            tick();
            start = 1'b0;
            clr   = 1'b0;
        end
    endtask

    initial begin
        int bc, dc, da;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_key_ready", {127'h0, key_ready}, 128'h0);
        chk("rst_done", {127'h0, done}, 128'h0);
        chk("rst_rd_data", rd_data, 128'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd(4'd5, 128'h0, "rst_buf5");

        // FIPS-197 key, with an ignored start three cycles in
        run_expand(fips[0], 3, -1, bc, dc, da);
        chk("fips_busy_cycles", 128'(bc), 128'd10);
        chk("fips_done_count", 128'(dc), 128'd1);
        chk("fips_done_at", 128'(da), 128'd10);
        chk("fips_key_ready", {127'h0, key_ready}, 128'h1);
        for (int i = 0; i <= 10; i++) rd(4'(i), fips[i], $sformatf("fips_rk%0d", i));
        for (int i = 11; i <= 15; i++) rd(4'(i), 128'h0, $sformatf("oob_idx%0d", i));

        // One-cycle read latency: output holds the old entry until the edge
        rd(4'd1, fips[1], "lat_pre");
        rd_idx = 4'd10;
        #2;
        chk("lat_hold", rd_data, fips[1]);
        @(posedge clk);
        #1;
        chk("lat_new", rd_data, fips[10]);

        // Restart from READY with an all-zero key
        start  = 1'b1;
        key_in = 128'h0;
        tick();
        start = 1'b0;
        chk("restart_ready_drop", {127'h0, key_ready}, 128'h0);
        chk("restart_busy", {127'h0, busy}, 128'h1);
        repeat (10) tick();
        chk("zero_done", {127'h0, done}, 128'h1);
        chk("zero_key_ready", {127'h0, key_ready}, 128'h1);
        rd(4'd0, 128'h0, "zero_rk0");
        rd(4'd1, 128'h62636363626363636263636362636363, "zero_rk1");
        rd(4'd2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, "zero_rk2");
        rd(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

        // clr from READY zeroizes everything
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_key_ready", {127'h0, key_ready}, 128'h0);
        chk("clr_rd_data", rd_data, 128'h0);
        for (int i = 0; i <= 10; i++) rd(4'(i), 128'h0, $sformatf("clr_rk%0d", i));

        // clr mid-expansion aborts with no done pulse
        run_expand(fips[0], -1, 4, bc, dc, da);
        chk("abort_done_count", 128'(dc), 128'd0);
        chk("abort_busy_cycles", 128'(bc), 128'd5);
        chk("abort_key_ready", {127'h0, key_ready}, 128'h0);
        rd(4'd1, 128'h0, "abort_rk1");

        // clr beats a simultaneous start
        start = 1'b1;
        clr   = 1'b1;
        tick();
        start = 1'b0;
        clr   = 1'b0;
        chk("clr_prio_busy", {127'h0, busy}, 128'h0);

        // Asynchronous reset between edges during EXPAND
        start  = 1'b1;
        key_in = fips[0];
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_busy", {127'h0, busy}, 128'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", {127'h0, busy}, 128'h0);
        chk("async_rd_data", rd_data, 128'h0);
        chk("async_key_ready", {127'h0, key_ready}, 128'h0);
        tick();
        rst_n = 1'b1;
        run_expand(fips[0], -1, -1, bc, dc, da);
        chk("post_rst_done_count", 128'(dc), 128'd1);
        rd(4'd1, fips[1], "post_rst_rk1");
        rd(4'd5, fips[5], "post_rst_rk5");
        rd(4'd10, fips[10], "post_rst_rk10");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
